// File: rtl/rv32i_types.sv
// Shared RV32I type definitions: memory funct3 encodings and the
// data-memory request FSM states.
package rv32i_types;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmem_state_t;

endpackage

// File: rtl/store_align.sv
// Combinational lane alignment for a memory access: byte enables, shifted
// store data and the alignment check.
module store_align
    import rv32i_types::*;
(
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    output logic [3:0]  mbe,
    output logic [31:0] wdata,
    output logic        misaligned
);

    always_comb begin
        wdata      = store_data << {offset, 3'b000};
        mbe        = 4'b1111;
        misaligned = 1'b0;
        if (req_write) begin
            case (store_funct3_t'(funct3))
                sb:      mbe = 4'b0001 << offset;
                sh:      mbe = 4'b0011 << offset;
                default: mbe = 4'b1111;
            endcase
        end
        // sh/sw share their encodings with lh/lw, so one check covers both.
        case (load_funct3_t'(funct3))
            lw:       misaligned = (offset != 2'b00);
            lh, lhu:  misaligned = offset[0];
            default:  misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_req_unit.sv
// MEM-stage data-memory request unit: issues one load/store per request,
// waits for the memory response and returns the lane-shifted load word.
module dmem_req_unit
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_mbe,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data,
    output logic        done,
    output logic        misaligned,
    output logic        stall
);

    dmem_state_t state;
    logic        write_q;
    logic [1:0]  offset_q;
    logic [3:0]  mbe_next;
    logic [31:0] wdata_next;
    logic        misaligned_next;

    store_align u_store_align (
        .req_write  (req_write),
        .funct3     (funct3),
        .offset     (addr[1:0]),
        .store_data (store_data),
        .mbe        (mbe_next),
        .wdata      (wdata_next),
        .misaligned (misaligned_next)
    );

    assign stall = req_valid && (state != DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            write_q      <= 1'b0;
            offset_q     <= 2'b00;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_address <= '0;
            dmem_wdata   <= '0;
            dmem_mbe     <= '0;
            load_data    <= '0;
            done         <= 1'b0;
            misaligned   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        offset_q <= addr[1:0];
                        if (misaligned_next) begin
                            // Illegal alignment completes without touching memory.
                            state      <= DONE;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else begin
                            state        <= BUSY;
                            dmem_read    <= ~req_write;
                            dmem_write   <= req_write;
                            dmem_address <= {addr[31:2], 2'b00};
                            dmem_wdata   <= wdata_next;
                            dmem_mbe     <= mbe_next;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_resp) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        if (!write_q)
                            load_data <= dmem_rdata >> {offset_q, 3'b000};
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    misaligned <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_req_unit.sv
// Randomized scoreboard bench for dmem_req_unit with a behavioural memory
// responder and a reference model of the access rules.
module tb_dmem_req_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic        dmem_resp = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [31:0] load_data;
    logic        done;
    logic        misaligned;
    logic        stall;

    dmem_req_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .dmem_address (dmem_address),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_wdata   (dmem_wdata),
        .dmem_mbe     (dmem_mbe),
        .dmem_resp    (dmem_resp),
        .dmem_rdata   (dmem_rdata),
        .load_data    (load_data),
        .done         (done),
        .misaligned   (misaligned),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mis;
        logic [31:0] load_data;
    } done_t;

    typedef struct {
        logic        w;
        logic [31:0] address;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  mbe;
        int          dly;
    } mem_t;

    done_t       exp_q[$];
    mem_t        mem_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          auto_mem = 1'b1;
    logic [31:0] last_load = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: derive the expected request and completion from the
    // access rules, then present the request and count the stall cycles.
    task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int dly);
        int          off = int'(a[1:0]);
        int          sz = int'(f3[1:0]);
        bit          mis;
        logic [3:0]  mbe;
        int          stalls = 0;
        int          cyc = 0;
        mem_t        m;
        done_t       e;
        mis = (sz == 2 && off != 0) || (sz == 1 && (off % 2) == 1);
        if (!w)           mbe = 4'hF;
        else if (sz == 0) mbe = 4'b0001 << off;
        else if (sz == 1) mbe = 4'b0011 << off;
        else              mbe = 4'hF;
        if (!w && !mis) last_load = rd >> (8 * off);
        e.mis = mis;
        e.load_data = last_load;
        exp_q.push_back(e);
        if (!mis) begin
            m.w = w;
            m.address = {a[31:2], 2'b00};
            m.wdata = sd << (8 * off);
            m.mbe = mbe;
            m.rdata = rd;
            m.dly = dly;
            mem_q.push_back(m);
        end
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        funct3 = f3;
        addr = a;
        store_data = sd;
        while (cyc < 100) begin
            #1;
            if (done) break;
            stalls += int'(stall);
            @(negedge clk);
            cyc++;
            // Inputs wander after acceptance; the unit must ignore them.
            req_write = 1'($urandom);
            funct3 = 3'($urandom);
            addr = $urandom;
            store_data = $urandom;
        end
        if (cyc >= 100) chk("done_timeout", {31'b0, done}, 32'd1);
        chk("stall_cycles", stalls, mis ? 1 : dly + 2);
    endtask

    // Memory responder: checks each request against the model, holds the
    // response back for the chosen delay, then pulses dmem_resp.
    initial begin : responder
        mem_t m;
        forever begin
            @(negedge clk);
            #1;
            if (auto_mem && !rst && (dmem_read || dmem_write)) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_req", {31'b0, dmem_read | dmem_write}, 32'd0);
                end else begin
                    m = mem_q.pop_front();
                    chk("req_write", {31'b0, dmem_write}, {31'b0, m.w});
                    chk("req_read", {31'b0, dmem_read}, {31'b0, ~m.w});
                    chk("req_address", dmem_address, m.address);
                    chk("req_mbe", {28'b0, dmem_mbe}, {28'b0, m.mbe});
                    if (m.w) chk("req_wdata", dmem_wdata, m.wdata);
                    for (int i = 0; i < m.dly; i++) begin
                        @(negedge clk);
                        #1;
                        chk("strobe_held", {31'b0, dmem_read | dmem_write}, 32'd1);
                        chk("address_held", dmem_address, m.address);
                    end
                    dmem_rdata = m.rdata;
                    dmem_resp = 1'b1;
                    @(negedge clk);
                    #1;
                    dmem_resp = 1'b0;
                    dmem_rdata = $urandom;
                    chk("strobe_drop", {31'b0, dmem_read | dmem_write}, 32'd0);
                end
            end
        end
    end

    initial begin : done_monitor
        done_t e;
        forever begin
            @(negedge clk);
            #1;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", {31'b0, done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
                    chk("load_data", load_data, e.load_data);
                end
            end else if (misaligned) begin
                chk("misaligned_without_done", {31'b0, misaligned}, 32'd0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [2:0] lf3 [5];
        lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;

        #2;
        chk("rst_read", {31'b0, dmem_read}, 32'd0);
        chk("rst_write", {31'b0, dmem_write}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
        chk("rst_address", dmem_address, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mbe", {28'b0, dmem_mbe}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner accesses.
        issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 3);
        req_valid = 1'b0;
        issue(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0);
        issue(1'b0, 3'b010, 32'h0000_3001, 32'h0, $urandom, 0);
        issue(1'b0, 3'b000, 32'h0000_5001, 32'h0, 32'h8899_AABB, 0);
        issue(1'b1, 3'b001, 32'h0000_5002, 32'h0000_1234, 32'h0, 0);
        req_valid = 1'b0;

        for (int n = 0; n < 40; n++) begin
            bit w;
            logic [2:0] f3;
            w = 1'($urandom);
            f3 = w ? 3'($urandom_range(2, 0)) : lf3[$urandom_range(4, 0)];
            issue(w, f3, $urandom, $urandom, $urandom, int'($urandom_range(4, 0)));
            if ($urandom_range(2, 0) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(2, 0)) @(negedge clk);
            end
        end
        req_valid = 1'b0;

        // Reset in the middle of an outstanding store, then a stray response.
        repeat (2) @(negedge clk);
        auto_mem = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        funct3 = 3'b010;
        addr = 32'h0000_4000;
        store_data = 32'hCAFE_F00D;
        @(negedge clk);
        #1;
        chk("busy_write", {31'b0, dmem_write}, 32'd1);
        chk("busy_address", dmem_address, 32'h0000_4000);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_write", {31'b0, dmem_write}, 32'd0);
        chk("async_rst_address", dmem_address, 32'd0);
        chk("async_rst_mbe", {28'b0, dmem_mbe}, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_load = '0;
        chk("rst_clears_load", load_data, 32'd0);
        @(negedge clk);
        dmem_resp = 1'b1;
        dmem_rdata = $urandom;
        @(negedge clk);
        dmem_resp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("idle_resp_no_done", {31'b0, done}, 32'd0);
            chk("idle_resp_no_strobe", {31'b0, dmem_read | dmem_write}, 32'd0);
        end
        auto_mem = 1'b1;
        issue(1'b0, 3'b010, 32'h0000_6004, 32'h0, 32'h1357_9BDF, 1);
        req_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("mem_q_drained", mem_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_req_unit.md
DMEM_REQ_UNIT -- requirements
Module: dmem_req_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as the codebase does: clk and rst.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  the MEM-stage instruction is a load or store.
REQ-005 req_write  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  size code: 000 b, 001 h, 010 w; loads also use 100 bu and 101 hu.
REQ-007 addr  input  32  byte address (ALU result).
REQ-008 store_data  input  32  rs2 value, right-aligned.
REQ-009 dmem_address  output  32  word-aligned address, addr[31:2] followed by 2'b00.
REQ-010 dmem_read / dmem_write  output  1 each  memory request strobes.
REQ-011 dmem_wdata  output  32  lane-shifted store data.
REQ-012 dmem_mbe  output  4  byte enables.
REQ-013 dmem_resp  input  1  memory completion, one-cycle pulse.
REQ-014 dmem_rdata  input  32  raw word from memory.
REQ-015 load_data  output  32  load word shifted right by 8*addr[1:0], so the target byte or half sits at bit 0 for the WB extension.
REQ-016 done  output  1  one-cycle pulse that marks the access complete and load_data valid.
REQ-017 misaligned  output  1  one-cycle pulse, concurrent with done, that flags an illegal alignment.
REQ-018 stall  output  1  freezes the pipeline while an access is outstanding.

Function
REQ-019 FSM states SHALL be IDLE, BUSY and DONE.
REQ-020 IDLE with req_valid=1 SHALL capture req_write, funct3, addr and store_data in the same edge.
- If aligned, go to BUSY.
- If misaligned, go to DONE with misaligned=1 and no memory access.
REQ-021 Misalignment SHALL be defined as:
- w: addr[1:0]!=0
- h or hu: addr[0]=1
- b and bu: never misaligned.
REQ-022 dmem_read, dmem_write, dmem_address, dmem_wdata and dmem_mbe SHALL be registered outputs.
- They assert the cycle after acceptance.
- They hold stable throughout BUSY.
REQ-023 Byte enables SHALL be:
- sb: 4'b0001<<addr[1:0]
- sh: 4'b0011<<addr[1:0]
- sw: 4'b1111
- loads: 4'b1111.
REQ-024 Store data SHALL be store_data<<(8*addr[1:0]), truncated to 32 bits.
REQ-025 BUSY with dmem_resp=1 SHALL:
- clear dmem_read and dmem_write at the next edge;
- register dmem_rdata>>(8*addr[1:0]) into load_data;
- go to DONE.
REQ-026 In DONE, done SHALL be 1 for exactly one cycle; the next state is always IDLE.
REQ-027 load_data SHALL hold its value until the next load completes; stores leave it unchanged.
REQ-028 stall SHALL equal req_valid AND (state != DONE), so a zero-wait access stalls exactly 2 cycles.
REQ-029 dmem_resp SHALL be ignored in IDLE and DONE.
REQ-030 Changes to req_valid or other inputs while BUSY SHALL have no effect.
REQ-031 BUSY SHALL have no timeout; the block waits indefinitely for dmem_resp.

Reset
REQ-032 rst=1 SHALL force the following immediately, without waiting for a clock edge:
- state=IDLE;
- dmem_read, dmem_write, done and misaligned = 0;
- dmem_address, dmem_wdata and load_data = 0;
- dmem_mbe = 0.
REQ-033 Reset during BUSY SHALL abandon the access; a later dmem_resp for it SHALL be ignored.
REQ-034 The first request SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-035 dmem_state_t (IDLE/BUSY/DONE) SHALL be added to rv32i_types, alongside the existing load_funct3_t and store_funct3_t, which this block SHALL use.
REQ-036 Combinational alignment of mbe, wdata and the misalignment check SHALL live in one sub-module, store_align.
REQ-037 The FSM and output registers SHALL live in dmem_req_unit.

Verification
REQ-038 sb at addr 0x1003, store_data 0x000000AB, resp 3 cycles later -> mbe=4'b1000, wdata=0xAB000000, address=0x1000, write held 3 cycles, done 1 cycle.
REQ-039 lhu at addr 0x2002, rdata 0xBEEF1234, immediate resp -> load_data=0x0000BEEF, stall high exactly 2 cycles.
REQ-040 lw at addr 0x3001 -> no dmem_read; misaligned=1 and done=1 on the same cycle, one cycle after accept.
REQ-041 sw at 0x4000, rst pulsed mid-BUSY then resp arrives -> write drops asynchronously; resp ignored; state IDLE; no done.
REQ-042 Back-to-back lb 0x5001 then sh 0x5002 with 0-wait memory -> load_data=rdata>>8; second access mbe=4'b1100; no lost or duplicated request.
REQ-043 dmem_resp pulsed in IDLE -> no state change, no done.
